// File: rtl/div_unit_if.sv
// div_unit_if: operand/result bundle between the HI/LO datapath and div_unit.
//   start     request a divide (requester -> divider)
//   dividend  signed dividend, sampled when start is accepted
//   divisor   signed divisor, sampled when start is accepted
//   hi        remainder, registered
//   lo        quotient, registered
//   div_zero  divisor was zero on the last accepted start
//   done      one-cycle pulse, hi/lo/div_zero valid
//   busy      divide in progress
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;
  logic             done;
  logic             busy;

  modport master (
    output start, dividend, divisor,
    input  hi, lo, div_zero, done, busy
  );

  modport slave (
    input  start, dividend, divisor,
    output hi, lo, div_zero, done, busy
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multicycle signed divider for MIPS DIV. Restoring radix-2 division
// on operand magnitudes, one quotient bit per cycle, then sign fix-up.
// Quotient truncates toward zero; the remainder takes the dividend's sign.
//   clk_i   system clock, rising edge
//   rst_i   synchronous, active-high reset
//   bus     div_unit_if slave: start/dividend/divisor in, hi/lo/div_zero/done/busy out
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | WIDTH shift/subtract steps
// SIGN   | apply signs, write hi/lo
// DONE   | done pulse for one cycle
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  div_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SIGN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;

  // One extra bit holds the bit shifted out of rem; diff[WIDTH] is the borrow.
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    trial   = {rem_q, quo_q[WIDTH-1]};
    diff    = trial - {1'b0, dvs_q};

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            dz_d    = 1'b0;
            // Unsigned magnitudes: |0x80000000| stays 0x80000000.
            quo_d   = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
            dvs_d   = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            rneg_d  = bus.dividend[WIDTH-1];
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        rem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = S_SIGN;
      end
      S_SIGN: begin
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;
  assign bus.done     = (state_q == S_DONE);
  assign bus.busy     = (state_q == S_RUN) || (state_q == S_SIGN);
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random divides; expected results come from 64-bit
// integer division and are queued at issue, then compared by an independent
// monitor whenever the divider pulses done.
module tb_div_unit;
  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  exp_t sb[$];
  logic [31:0] m_lo;
  logic [31:0] m_hi;

  div_unit_if #(.WIDTH(32)) bus();

  div_unit #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("lo", bus.lo, e.lo);
        check("hi", bus.hi, e.hi);
        check("div_zero", {31'd0, bus.div_zero}, {31'd0, e.dz});
      end
    end
  end

  // Signed truncating division in 64 bits: no overflow for 0x80000000 / -1.
  task automatic model(input logic [31:0] a, input logic [31:0] b, output exp_t e);
    longint sa, sbv, q, r;
    if (b == 32'd0) begin
      e = '{lo: m_lo, hi: m_hi, dz: 1'b1};
    end else begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      q   = sa / sbv;
      r   = sa % sbv;
      e   = '{lo: q[31:0], hi: r[31:0], dz: 1'b0};
      m_lo = e.lo;
      m_hi = e.hi;
    end
  endtask

  // Called with the DUT idle, #1 after a rising edge.
  // poke_at: cycle at which a 1/1 start is pulsed mid-operation (-1 = never).
  // abort_at: cycle at which reset is asserted mid-operation (-1 = never).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input int abort_at);
    exp_t e;
    int   lat;
    int   bcnt;
    int   exp_lat;
    model(a, b, e);
    sb.push_back(e);
    exp_lat = (b == 32'd0) ? 0 : 33;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    lat  = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 60) begin
      if (lat == abort_at) begin
        rst = 1'b1;
        sb.delete();
        m_lo = '0;
        m_hi = '0;
        @(posedge clk); #1;
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
        rst = 1'b0;
        return;
      end
      if (lat == poke_at) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd1;
        bus.divisor  = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    check("latency", lat, exp_lat);
    check("busy_cycles", bcnt, exp_lat);
    @(posedge clk); #1;
    check("done_pulse_width", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    tests = 0;
    fails = 0;
    m_lo  = '0;
    m_hi  = '0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_div_zero", {31'd0, bus.div_zero}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'd7, 32'd2, -1, -1);
    run_op(-32'sd7, 32'd2, -1, -1);
    run_op(32'd7, -32'sd2, -1, -1);
    run_op(-32'sd7, -32'sd2, -1, -1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op(32'd5, 32'd0, -1, -1);
    run_op(32'd9, 32'd3, -1, -1);
    run_op(32'd100, 32'd7, 4, -1);
    run_op(32'd12345, 32'd17, -1, 10);
    run_op(32'd9, 32'd4, -1, -1);
    run_op(32'h8000_0000, 32'h8000_0000, -1, -1);
    run_op(32'h7FFF_FFFF, 32'h8000_0000, -1, -1);
    run_op(32'd0, 32'd3, -1, -1);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 1) == 1) b = -b;
      if (b == 32'd0) b = 32'd1;
      run_op(a, b, -1, -1);
    end

    @(posedge clk); #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
